// File: rtl/pkt_mem_writer.sv
// -----------------------------------------------------------------------------
// pkt_mem_writer
//
// Packs an 8-bit start/end-of-packet framed byte stream little-endian into
// 32-bit words and writes them into a circular region of a single-port packet
// memory over an Avalon-MM write-only master. Each packet occupies one header
// word ({trunc, 15'b0, byte_count}) followed by its payload words. A
// completion pulse reports where the packet landed.
//
// Ports
//   clk, reset_n      system clock, asynchronous active-low reset
//   in_data[7:0]      stream byte
//   in_valid          byte valid
//   in_sop / in_eop   first / last byte of packet
//   in_ready          byte accepted when in_valid & in_ready
//   rd_ptr            consumer's next unread word address
//   wr_ptr            word address where the next packet's header goes
//   avm_address       memory word address
//   avm_byteenable    lane enables
//   avm_chipselect    mirrors avm_write
//   avm_write         single-cycle write strobe (memory has no wait states)
//   avm_writedata     write data
//   avm_clken         tied high
//   pkt_done          one-cycle completion pulse
//   pkt_addr          header address of the completed packet
//   pkt_len           stored byte count of the completed packet
//   pkt_trunc         completed packet was truncated
// -----------------------------------------------------------------------------
module pkt_mem_writer #(
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 51200,
    parameter int MAX_WORDS = 380
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              avm_clken,
    output logic              pkt_done,
    output logic [ADDR_W-1:0] pkt_addr,
    output logic [15:0]       pkt_len,
    output logic              pkt_trunc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_DISCARD,
        S_FLUSH,
        S_HDR
    } state_e;

    localparam logic [15:0]       MAX_BYTES = 16'(MAX_WORDS * 4);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    // free >= MAX_WORDS+1  <=>  used <= DEPTH-2-MAX_WORDS
    localparam logic [31:0]       USED_MAX  = 32'(DEPTH - 2 - MAX_WORDS);

    // Ring addresses wrap at DEPTH, not at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (a == LAST_ADDR) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    // Lanes filled after a byte lands, keyed by the low bits of the new count.
    function automatic logic [3:0] lanes_be(input logic [1:0] cnt_lsb);
        case (cnt_lsb)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] hdr_q, hdr_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;   // next payload word address
    logic [15:0]       count_q, count_d;
    logic              trunc_q, trunc_d;
    logic [31:0]       word_q, word_d;     // partially packed payload word

    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       data_q, data_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] done_addr_q, done_addr_d;
    logic [15:0]       done_len_q, done_len_d;
    logic              done_trunc_q, done_trunc_d;

    // ------------------------------------------------------------------
    // Ring occupancy. used = (wr_ptr - rd_ptr) mod DEPTH, one extra bit
    // so the wrapped sum cannot overflow.
    // ------------------------------------------------------------------
    logic [ADDR_W:0] used;
    logic            space_ok;

    always_comb begin
        if (wr_ptr_q >= rd_ptr) begin
            used = {1'b0, wr_ptr_q} - {1'b0, rd_ptr};
        end else begin
            used = {1'b0, wr_ptr_q} + DEPTH_X - {1'b0, rd_ptr};
        end
        space_ok = (32'(used) <= USED_MAX);
    end

    // in_ready is combinational so an rd_ptr update opens the gate in the
    // same cycle; held low while reset is asserted.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_IDLE:            in_ready = space_ok;
            S_DATA, S_DISCARD: in_ready = 1'b1;
            default:           in_ready = 1'b0;
        endcase
        in_ready = in_ready & reset_n;
    end

    logic accept;
    assign accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Byte packing shared by the first byte (IDLE) and the rest (DATA).
    // ------------------------------------------------------------------
    logic        first_byte;
    logic [1:0]  lane;
    logic [31:0] packed_word;
    logic [15:0] new_count;
    logic [ADDR_W-1:0] word_addr;

    always_comb begin
        first_byte  = (state_q == S_IDLE);
        lane        = first_byte ? 2'd0 : count_q[1:0];
        // Lane 0 starts a fresh word so unfilled upper lanes read as zero.
        packed_word = ((lane == 2'd0) ? 32'd0 : word_q) |
                      ({24'd0, in_data} << {lane, 3'b000});
        new_count   = first_byte ? 16'd1 : count_q + 16'd1;
        word_addr   = first_byte ? addr_inc(wr_ptr_q) : paddr_q;
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        hdr_d        = hdr_q;
        paddr_d      = paddr_q;
        count_d      = count_q;
        trunc_d      = trunc_q;
        word_d       = word_q;
        wr_d         = 1'b0;
        addr_d       = addr_q;
        be_d         = be_q;
        data_d       = data_q;
        done_d       = 1'b0;
        done_addr_d  = done_addr_q;
        done_len_d   = done_len_q;
        done_trunc_d = done_trunc_q;

        case (state_q)
            S_IDLE, S_DATA: begin
                // Stray bytes without sop in IDLE are accepted and dropped.
                if (accept && (!first_byte || in_sop)) begin
                    word_d  = packed_word;
                    count_d = new_count;
                    paddr_d = word_addr;
                    if (first_byte) begin
                        hdr_d   = wr_ptr_q;
                        trunc_d = 1'b0;
                    end
                    // A full word, or the partial word at eop, is written on
                    // the following cycle (FLUSH for the eop case).
                    if (lane == 2'd3 || in_eop) begin
                        wr_d    = 1'b1;
                        addr_d  = word_addr;
                        data_d  = packed_word;
                        be_d    = lanes_be(new_count[1:0]);
                        paddr_d = addr_inc(word_addr);
                    end
                    if (in_eop) begin
                        state_d = S_FLUSH;
                    end else if (new_count == MAX_BYTES) begin
                        state_d = S_DISCARD;
                        trunc_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DISCARD: begin
                if (accept && in_eop) begin
                    state_d = S_FLUSH;
                end
            end

            S_FLUSH: begin
                // Any pending payload write is already on the bus this cycle;
                // queue the header so it lands in HDR.
                state_d      = S_HDR;
                wr_d         = 1'b1;
                addr_d       = hdr_q;
                data_d       = {trunc_q, 15'd0, count_q};
                be_d         = 4'b1111;
                done_d       = 1'b1;
                done_addr_d  = hdr_q;
                done_len_d   = count_q;
                done_trunc_d = trunc_q;
                wr_ptr_d     = paddr_q;
            end

            S_HDR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its peers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            hdr_q        <= '0;
            paddr_q      <= '0;
            count_q      <= '0;
            trunc_q      <= 1'b0;
            word_q       <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            done_addr_q  <= '0;
            done_len_q   <= '0;
            done_trunc_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            hdr_q        <= hdr_d;
            paddr_q      <= paddr_d;
            count_q      <= count_d;
            trunc_q      <= trunc_d;
            word_q       <= word_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            data_q       <= data_d;
            done_q       <= done_d;
            done_addr_q  <= done_addr_d;
            done_len_q   <= done_len_d;
            done_trunc_q <= done_trunc_d;
        end
    end

    assign wr_ptr         = wr_ptr_q;
    assign avm_address    = addr_q;
    assign avm_byteenable = be_q;
    assign avm_write      = wr_q;
    assign avm_chipselect = wr_q;
    assign avm_writedata  = data_q;
    assign avm_clken      = 1'b1;
    assign pkt_done       = done_q;
    assign pkt_addr       = done_addr_q;
    assign pkt_len        = done_len_q;
    assign pkt_trunc      = done_trunc_q;

endmodule

// File: tb/tb_pkt_mem_writer.sv
// -----------------------------------------------------------------------------
// tb_pkt_mem_writer
//
// Directed bench for pkt_mem_writer on a small 16-word ring with 4-word
// packets. A monitor logs every memory write and completion pulse with its
// cycle number; the stimulus sequence then compares the log against
// hand-computed addresses, data, byte enables and latencies.
// -----------------------------------------------------------------------------
module tb_pkt_mem_writer;

    localparam int ADDR_W    = 16;
    localparam int DEPTH     = 16;
    localparam int MAX_WORDS = 4;

    logic              clk;
    logic              reset_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_sop;
    logic              in_eop;
    logic              in_ready;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_clken;
    logic              pkt_done;
    logic [ADDR_W-1:0] pkt_addr;
    logic [15:0]       pkt_len;
    logic              pkt_trunc;

    pkt_mem_writer #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .MAX_WORDS(MAX_WORDS)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_sop        (in_sop),
        .in_eop        (in_eop),
        .in_ready      (in_ready),
        .rd_ptr        (rd_ptr),
        .wr_ptr        (wr_ptr),
        .avm_address   (avm_address),
        .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect),
        .avm_write     (avm_write),
        .avm_writedata (avm_writedata),
        .avm_clken     (avm_clken),
        .pkt_done      (pkt_done),
        .pkt_addr      (pkt_addr),
        .pkt_len       (pkt_len),
        .pkt_trunc     (pkt_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        cs;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] len;
        logic        trunc;
        logic [15:0] wp;
        int          cyc;
    } done_t;

    wr_t   wq[$];
    done_t dq[$];
    int    acc_q[$];

    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (avm_write) wq.push_back('{avm_address, avm_byteenable, avm_writedata, avm_chipselect, cyc});
        if (pkt_done)  dq.push_back('{pkt_addr, pkt_len, pkt_trunc, wr_ptr, cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until accepted (bounded); returns just
    // after the accepting edge with in_valid dropped.
    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int waited;
        waited   = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_sop   = s;
        in_eop   = e;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        check("in_ready_at_accept", {31'd0, in_ready}, 32'd1);
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    // Consecutive byte values starting at 'first', sop on the first, eop on the last.
    task automatic send_pkt(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            send_byte(first + 8'(i), i == 0, i == n - 1);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input string tag, input int idx, input logic [15:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        if (idx >= wq.size()) begin
            check({tag, "_present"}, 32'(wq.size()), 32'(idx + 1));
        end else begin
            check({tag, "_addr"}, {16'd0, wq[idx].addr}, {16'd0, a});
            check({tag, "_be"},   {28'd0, wq[idx].be},   {28'd0, be});
            check({tag, "_data"}, wq[idx].data, d);
            check({tag, "_cs"},   {31'd0, wq[idx].cs},   32'd1);
        end
    endtask

    task automatic exp_done(input string tag, input int idx, input logic [15:0] a,
                            input logic [15:0] len, input logic tr, input logic [15:0] wp);
        if (idx >= dq.size()) begin
            check({tag, "_present"}, 32'(dq.size()), 32'(idx + 1));
        end else begin
            check({tag, "_addr"},  {16'd0, dq[idx].addr}, {16'd0, a});
            check({tag, "_len"},   {16'd0, dq[idx].len},  {16'd0, len});
            check({tag, "_trunc"}, {31'd0, dq[idx].trunc}, {31'd0, tr});
            check({tag, "_wrptr"}, {16'd0, dq[idx].wp},   {16'd0, wp});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ptr"},   {16'd0, wr_ptr}, 32'd0);
        check({tag, "_avm_write"}, {31'd0, avm_write}, 32'd0);
        check({tag, "_avm_cs"},    {31'd0, avm_chipselect}, 32'd0);
        check({tag, "_avm_addr"},  {16'd0, avm_address}, 32'd0);
        check({tag, "_avm_be"},    {28'd0, avm_byteenable}, 32'd0);
        check({tag, "_avm_data"},  avm_writedata, 32'd0);
        check({tag, "_avm_clken"}, {31'd0, avm_clken}, 32'd1);
        check({tag, "_pkt_done"},  {31'd0, pkt_done}, 32'd0);
        check({tag, "_pkt_addr"},  {16'd0, pkt_addr}, 32'd0);
        check({tag, "_pkt_len"},   {16'd0, pkt_len}, 32'd0);
        check({tag, "_pkt_trunc"}, {31'd0, pkt_trunc}, 32'd0);
        check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, db, ab;

        reset_n  = 1'b0;
        in_data  = 8'd0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        rd_ptr   = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        settle(1);
        check("idle_ready_empty", {31'd0, in_ready}, 32'd1);

        // ---------------- basic 5-byte packet ----------------
        wb = wq.size(); db = dq.size(); ab = acc_q.size();
        send_pkt(5, 8'h01);
        settle(4);
        check("basic_nwrites", 32'(wq.size() - wb), 32'd3);
        exp_wr("basic_w0", wb,     16'd1, 4'b1111, 32'h04030201);
        exp_wr("basic_w1", wb + 1, 16'd2, 4'b0001, 32'h00000005);
        exp_wr("basic_hdr", wb + 2, 16'd0, 4'b1111, 32'h00000005);
        exp_done("basic_done", db, 16'd0, 16'd5, 1'b0, 16'd3);
        if (wq.size() >= wb + 3 && dq.size() > db) begin
            check("basic_word_latency", 32'(wq[wb].cyc),     32'(acc_q[ab + 3] + 1));
            check("basic_flush_cycle",  32'(wq[wb + 1].cyc), 32'(acc_q[ab + 4] + 1));
            check("basic_hdr_cycle",    32'(wq[wb + 2].cyc), 32'(acc_q[ab + 4] + 2));
            check("basic_done_cycle",   32'(dq[db].cyc),     32'(acc_q[ab + 4] + 2));
        end
        check("basic_wr_ptr", {16'd0, wr_ptr}, 32'd3);

        // ---------------- stray bytes without sop ----------------
        wb = wq.size(); db = dq.size();
        send_byte(8'h77, 1'b0, 1'b0);
        send_byte(8'h78, 1'b0, 1'b1);
        send_byte(8'h79, 1'b0, 1'b0);
        settle(4);
        check("stray_nwrites", 32'(wq.size() - wb), 32'd0);
        check("stray_ndone",   32'(dq.size() - db), 32'd0);
        check("stray_wr_ptr",  {16'd0, wr_ptr}, 32'd3);

        // ---------------- single byte sop+eop ----------------
        wb = wq.size(); db = dq.size();
        send_pkt(1, 8'hAA);
        settle(4);
        check("single_nwrites", 32'(wq.size() - wb), 32'd2);
        exp_wr("single_w0",  wb,     16'd4, 4'b0001, 32'h000000AA);
        exp_wr("single_hdr", wb + 1, 16'd3, 4'b1111, 32'h00000001);
        exp_done("single_done", db, 16'd3, 16'd1, 1'b0, 16'd5);

        // ---------------- truncation: 20 bytes, 16 kept ----------------
        wb = wq.size(); db = dq.size();
        send_pkt(20, 8'h01);
        settle(4);
        check("trunc_nwrites", 32'(wq.size() - wb), 32'd5);
        exp_wr("trunc_w0",  wb,     16'd6, 4'b1111, 32'h04030201);
        exp_wr("trunc_w1",  wb + 1, 16'd7, 4'b1111, 32'h08070605);
        exp_wr("trunc_w2",  wb + 2, 16'd8, 4'b1111, 32'h0C0B0A09);
        exp_wr("trunc_w3",  wb + 3, 16'd9, 4'b1111, 32'h100F0E0D);
        exp_wr("trunc_hdr", wb + 4, 16'd5, 4'b1111, 32'h80000010);
        exp_done("trunc_done", db, 16'd5, 16'd16, 1'b1, 16'd10);

        // ---------------- wrap-around with rd_ptr tracking ----------------
        rd_ptr = 16'd10;
        send_pkt(1, 8'h11);
        settle(4);
        rd_ptr = 16'd12;
        send_pkt(1, 8'h22);
        settle(4);
        check("wrap_pre_wr_ptr", {16'd0, wr_ptr}, 32'd14);
        rd_ptr = 16'd14;
        wb = wq.size(); db = dq.size();
        send_pkt(8, 8'h31);
        settle(4);
        check("wrap_nwrites", 32'(wq.size() - wb), 32'd3);
        exp_wr("wrap_w0",  wb,     16'd15, 4'b1111, 32'h34333231);
        exp_wr("wrap_w1",  wb + 1, 16'd0,  4'b1111, 32'h38373635);
        exp_wr("wrap_hdr", wb + 2, 16'd14, 4'b1111, 32'h00000008);
        exp_done("wrap_done", db, 16'd14, 16'd8, 1'b0, 16'd1);

        // ---------------- space check across the wrap (wr=1) ----------------
        rd_ptr = 16'd6;   // used = 11, free = 4
        #1;
        check("space_wrapped_full", {31'd0, in_ready}, 32'd0);
        rd_ptr = 16'd7;   // used = 10, free = 5
        #1;
        check("space_wrapped_ok", {31'd0, in_ready}, 32'd1);

        // advance wr_ptr from 1 to 11 with single-byte packets
        for (int k = 0; k < 5; k++) begin
            rd_ptr = 16'(1 + 2 * k);
            send_pkt(1, 8'h40 + 8'(k));
            settle(4);
        end
        check("full_pre_wr_ptr", {16'd0, wr_ptr}, 32'd11);

        // ---------------- full: rd=0, wr=11 ----------------
        rd_ptr = 16'd0;
        wb = wq.size(); db = dq.size();
        in_data  = 8'h5A;
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_eop   = 1'b1;
        repeat (3) @(negedge clk);
        check("full_ready_low", {31'd0, in_ready}, 32'd0);
        check("full_no_write",  32'(wq.size() - wb), 32'd0);
        check("full_wr_ptr_hold", {16'd0, wr_ptr}, 32'd11);
        rd_ptr = 16'd1;
        #1;
        check("full_ready_same_cycle", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        settle(4);
        exp_wr("full_w0",  wb,     16'd12, 4'b0001, 32'h0000005A);
        exp_wr("full_hdr", wb + 1, 16'd11, 4'b1111, 32'h00000001);
        exp_done("full_done", db, 16'd11, 16'd1, 1'b0, 16'd13);

        // ---------------- reset mid-packet ----------------
        rd_ptr = 16'd13;
        wb = wq.size(); db = dq.size();
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h61 + 8'(i), i == 0, 1'b0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd_ptr  = 16'd0;
        settle(4);
        check("midrst_nwrites", 32'(wq.size() - wb), 32'd1);
        exp_wr("midrst_w0", wb, 16'd14, 4'b1111, 32'h64636261);
        check("midrst_ndone", 32'(dq.size() - db), 32'd0);
        check("midrst_wr_ptr", {16'd0, wr_ptr}, 32'd0);

        wb = wq.size(); db = dq.size();
        send_pkt(3, 8'h71);
        settle(4);
        check("post_nwrites", 32'(wq.size() - wb), 32'd2);
        exp_wr("post_w0",  wb,     16'd1, 4'b0111, 32'h00737271);
        exp_wr("post_hdr", wb + 1, 16'd0, 4'b1111, 32'h00000003);
        exp_done("post_done", db, 16'd0, 16'd3, 1'b0, 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_mem_writer.md
# pkt_mem_writer

Upstream feeder for the single-port on-chip packet memory. Accepts a byte stream with start/end-of-packet framing, packs the bytes little-endian into 32-bit words, and writes them into a circular buffer region in the memory through the memory's Avalon slave port. Each packet is preceded by a header word holding its byte length. A completion pulse tells the consumer where the packet sits.

## Interface
Parameters:
- ADDR_W, 16, memory word-address width
- DEPTH, 51200, ring size in words; addresses run 0..DEPTH-1
- MAX_WORDS, 380, maximum payload words per packet; MAX_WORDS*4 < 65536

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  byte valid
- in_sop  in  1  first byte of packet
- in_eop  in  1  last byte of packet
- in_ready  out  1  byte accepted when in_valid & in_ready
- rd_ptr  in  ADDR_W  consumer's next unread word address
- wr_ptr  out  ADDR_W  word address where the next packet's header goes
- avm_address  out  ADDR_W  memory word address
- avm_byteenable  out  4  lane enables
- avm_chipselect  out  1  equals avm_write
- avm_write  out  1  single-cycle write strobe
- avm_writedata  out  32  write data
- avm_clken  out  1  constant 1
- pkt_done  out  1  one-cycle pulse when a packet is complete
- pkt_addr  out  ADDR_W  header address of the completed packet
- pkt_len  out  16  stored byte count
- pkt_trunc  out  1  packet was truncated

## Operation
- Memory has no wait state. Every avm_write cycle completes in that cycle.
- Reset values: all outputs 0 except avm_clken=1. State IDLE, wr_ptr=0.
- Space check:
  - used = (wr_ptr - rd_ptr) mod DEPTH
  - free = DEPTH-1-used
  - ok = free >= MAX_WORDS+1
- States: IDLE, DATA, DISCARD, FLUSH, HDR.
- IDLE:
  - in_ready = ok.
  - An accepted byte without in_sop is dropped.
  - An accepted byte with in_sop:
    - hdr = wr_ptr; payload address = wr_ptr+1 (mod DEPTH).
    - Byte goes to lane 0; count=1.
    - Go to DATA. If in_eop is also set, go to FLUSH instead.
- DATA:
  - in_ready=1. Each accepted byte goes to lane (count mod 4); count increments.
  - in_sop is ignored.
  - On the 4th lane, the word is written next cycle with byteenable 1111, and the payload address increments mod DEPTH.
  - eop -> FLUSH.
  - Reaching count = MAX_WORDS*4 without eop -> DISCARD and trunc=1.
- DISCARD:
  - in_ready=1. Bytes are dropped; count is frozen.
  - eop -> FLUSH.
- FLUSH:
  - in_ready=0.
  - If a partial word is pending, write it with byteenable = lanes filled: 0001, 0011 or 0111. Otherwise no write.
- HDR:
  - in_ready=0.
  - Write to address hdr: data = {trunc, 15'b0, count}, byteenable 1111.
  - pkt_done=1, pkt_addr=hdr, pkt_len=count, pkt_trunc=trunc.
  - wr_ptr updates to the address after the last payload word (mod DEPTH).
  - Go to IDLE.
- All address arithmetic wraps at DEPTH (compare with DEPTH-1, then 0), not at 2^ADDR_W.
- Reset mid-packet: partial packet abandoned, no header written, wr_ptr=0.

## Timing
- Write latency: a byte completing a word at cycle N produces avm_write at N+1. Writes are registered.
- At most one write per 4 accepted bytes in DATA, so payload writes never collide.
- eop accepted at cycle N:
  - N+1: FLUSH. Partial payload word written, if any.
  - N+2: HDR. Header write, pkt_done, wr_ptr update.
  - N+3: IDLE. in_ready reflects ok from the new wr_ptr.
- Minimum packet gap: 2 cycles with in_ready low.
- in_ready in IDLE is combinational from wr_ptr and rd_ptr. An rd_ptr change is visible the same cycle.

## Test plan
- Basic packet: after reset, rd_ptr=0, send 5-byte packet 01..05.
  - Writes: addr1 0x04030201 be1111; addr2 0x00000005 be0001; addr0 0x00000005 be1111.
  - pkt_done with addr 0, len 5; wr_ptr=3.
- Wrap-around: DEPTH=16, MAX_WORDS=4, rd_ptr tracking wr_ptr. Advance wr_ptr to 14, then send 8 bytes.
  - Header at 14, payload at 15 and 0; wr_ptr=1.
- Full: DEPTH=16, MAX_WORDS=4, rd_ptr=0, wr_ptr=11 (free 4).
  - in_ready=0 with sop held.
  - Set rd_ptr=1 -> in_ready=1 in the same cycle; packet accepted.
- Truncation: MAX_WORDS=4, 20-byte packet.
  - Four payload writes, bytes 17..20 dropped.
  - Header 0x80000010; pkt_len=16, pkt_trunc=1.
- Framing edge cases:
  - Stray bytes without sop in IDLE -> no writes.
  - Single-byte sop+eop 0xAA -> payload 0x000000AA be0001, header 0x00000001, wr_ptr+2.
- Reset mid-packet: reset_n low after 6 bytes.
  - All outputs return to reset values; no header written; wr_ptr=0.
  - Next packet header lands at 0.
